// File: rtl/ntt_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 NTT with an in-order tag FIFO.
// Define NTT_CTRL_BITREV_EN to bit-reverse final-stage write addresses (natural-order output).
module ntt_stage_ctrl #(
    parameter int LOGN       = 3,
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = PIPE_LAT + 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_x,
    output logic [LOGN-1:0] rd_addr_y,
    output logic [LOGN-2:0] tw_addr,
    output logic            bf_en,
    input  logic            bf_valid,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_x,
    output logic [LOGN-1:0] wr_addr_y
);

    localparam int HALF = 1 << (LOGN - 1);
    localparam int JW   = LOGN - 1;
    localparam int SW   = $clog2(LOGN + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   s_q;
    logic [JW-1:0]   j_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            rd_en_q;
    logic            bf_en_q;
    logic [LOGN-1:0] rd_x_q;
    logic [LOGN-1:0] rd_y_q;
    logic [JW-1:0]   tw_q;

    logic [SW-1:0]   a_s;
    logic [JW-1:0]   a_j;
    logic [LOGN-1:0] span;
    logic [LOGN-1:0] a_x;
    logic [LOGN-1:0] a_y;
    logic [JW-1:0]   kmask;
    logic [JW-1:0]   g;
    logic [JW-1:0]   k;
    logic [JW-1:0]   a_tw;
    int              shg;
    int              shx;

    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   wp_q;
    logic [PW-1:0]   rp_q;
    logic [LOGN-1:0] mem_x_q [FIFO_DEPTH];
    logic [LOGN-1:0] mem_y_q [FIFO_DEPTH];
    logic [LOGN-1:0] wx_q;
    logic [LOGN-1:0] wy_q;
    logic [LOGN-1:0] tag_x;
    logic [LOGN-1:0] tag_y;
    logic            act;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef NTT_CTRL_BITREV_EN
    function automatic logic [LOGN-1:0] brev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction
`endif

    // Butterfly (stage, index) that will be presented in the next cycle.
    always_comb begin
        a_s = '0;
        a_j = '0;
        unique case (state_q)
            ISSUE: begin
                a_s = s_q;
                a_j = j_q + JW'(1);
            end
            DRAIN: a_s = s_q + SW'(1);
            default: ;
        endcase
    end

    always_comb begin
        shg   = LOGN - 1 - int'(a_s);
        shx   = LOGN - int'(a_s);
        span  = LOGN'(HALF) >> a_s;
        kmask = JW'(HALF - 1) >> a_s;
        g     = a_j >> shg;
        k     = a_j & kmask;
        a_x   = ({1'b0, g} << shx) + {1'b0, k};
        a_y   = a_x + span;
        a_tw  = k << a_s;
    end

    always_comb begin
        tag_x = rd_x_q;
        tag_y = rd_y_q;
`ifdef NTT_CTRL_BITREV_EN
        if (s_q == SW'(LOGN - 1)) begin
            tag_x = brev(rd_x_q);
            tag_y = brev(rd_y_q);
        end
`endif
    end

    assign act   = (state_q == ISSUE) || (state_q == DRAIN);
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign push  = rd_en_q && !full;
    assign pop   = bf_valid && act && !empty;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_x_q  <= '0;
            rd_y_q  <= '0;
            tw_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        s_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_x_q  <= a_x;
                        rd_y_q  <= a_y;
                        tw_q    <= a_tw;
                    end
                end
                ISSUE: begin
                    if (j_q == JW'(HALF - 1)) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        j_q    <= a_j;
                        rd_x_q <= a_x;
                        rd_y_q <= a_y;
                        tw_q   <= a_tw;
                    end
                end
                DRAIN: begin
                    // Next stage reads this stage's results, so wait for an empty FIFO.
                    if (cnt_d == '0) begin
                        if (s_q == SW'(LOGN - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            s_q     <= a_s;
                            j_q     <= '0;
                            rd_en_q <= 1'b1;
                            rd_x_q  <= a_x;
                            rd_y_q  <= a_y;
                            tw_q    <= a_tw;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            err_q   <= 1'b0;
            bf_en_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bf_en_q <= rd_en_q;
            if (push) begin
                wp_q <= ptr_inc(wp_q);
            end
            if (pop) begin
                rp_q <= ptr_inc(rp_q);
                wx_q <= mem_x_q[rp_q];
                wy_q <= mem_y_q[rp_q];
            end
            if ((rd_en_q && full) || (bf_valid && !pop)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x_q[wp_q] <= tag_x;
            mem_y_q[wp_q] <= tag_y;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_x = rd_x_q;
    assign rd_addr_y = rd_y_q;
    assign tw_addr   = tw_q;
    assign bf_en     = bf_en_q;
    assign wr_en     = pop;
    assign wr_addr_x = pop ? mem_x_q[rp_q] : wx_q;
    assign wr_addr_y = pop ? mem_y_q[rp_q] : wy_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: cycle-exact directed runs plus random-latency scoreboard runs.
// Honours NTT_CTRL_BITREV_EN in the expected final-stage write addresses.
module tb_ntt_stage_ctrl;

    localparam int LOGN   = 3;
    localparam int LAT    = 4;
    localparam int N      = 1 << LOGN;
    localparam int HALF   = N / 2;
    localparam int NP     = LOGN * HALF;
    localparam int STG    = HALF + 1 + LAT;
    localparam int DONE_C = LOGN * STG + 1;
    localparam int MAXC   = DONE_C + 4;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic            start    = 1'b0;
    logic            bf_valid = 1'b0;
    logic            busy, done, err, rd_en, bf_en, wr_en;
    logic [LOGN-1:0] rd_addr_x, rd_addr_y, wr_addr_x, wr_addr_y;
    logic [LOGN-2:0] tw_addr;

    int checks   = 0;
    int failures = 0;

    int exp_rx[NP], exp_ry[NP], exp_tw[NP], exp_wx[NP], exp_wy[NP];
    int e_rp[MAXC+1];
    int e_wp[MAXC+1];
    bit e_bf[MAXC+1];

    int          lat_lo = LAT;
    int          lat_hi = LAT;
    logic        inj    = 1'b0;
    int unsigned tcyc   = 0;
    int unsigned due_q[$];

    ntt_stage_ctrl #(
        .LOGN     (LOGN),
        .PIPE_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr_x (rd_addr_x),
        .rd_addr_y (rd_addr_y),
        .tw_addr   (tw_addr),
        .bf_en     (bf_en),
        .bf_valid  (bf_valid),
        .wr_en     (wr_en),
        .wr_addr_x (wr_addr_x),
        .wr_addr_y (wr_addr_y)
    );

    always #5 clk = ~clk;

    // Butterfly model: in-order results after a latency drawn from [lat_lo, lat_hi].
    always @(negedge clk) begin
        tcyc++;
        if (reset) begin
            due_q.delete();
            bf_valid = 1'b0;
        end else begin
            if (bf_en) begin
                int unsigned d;
                d = tcyc + $urandom_range(lat_hi, lat_lo);
                if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
                due_q.push_back(d);
            end
            bf_valid = inj;
            if (due_q.size() > 0 && due_q[0] == tcyc) begin
                void'(due_q.pop_front());
                bf_valid = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #2;
    endtask

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOGN; i++) r |= ((v >> i) & 1) << (LOGN - 1 - i);
        return r;
    endfunction

    task automatic build_model();
        int p;
        p = 0;
        for (int s = 0; s < LOGN; s++) begin
            int span;
            span = N >> (s + 1);
            for (int b = 0; b < N; b += 2 * span) begin
                for (int k = 0; k < span; k++) begin
                    exp_rx[p] = b + k;
                    exp_ry[p] = b + k + span;
                    exp_tw[p] = k << s;
                    exp_wx[p] = exp_rx[p];
                    exp_wy[p] = exp_ry[p];
`ifdef NTT_CTRL_BITREV_EN
                    if (s == LOGN - 1) begin
                        exp_wx[p] = brev(exp_rx[p]);
                        exp_wy[p] = brev(exp_ry[p]);
                    end
`endif
                    p++;
                end
            end
        end
        for (int c = 0; c <= MAXC; c++) begin
            e_rp[c] = -1;
            e_wp[c] = -1;
            e_bf[c] = 1'b0;
        end
        for (int q = 0; q < NP; q++) begin
            int c;
            c = 1 + (q / HALF) * STG + (q % HALF);
            e_rp[c]           = q;
            e_bf[c + 1]       = 1'b1;
            e_wp[c + 1 + LAT] = q;
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_err"}, err, 0);
        chk({pfx, "_rd_en"}, rd_en, 0);
        chk({pfx, "_bf_en"}, bf_en, 0);
        chk({pfx, "_wr_en"}, wr_en, 0);
        chk({pfx, "_rd_x"}, rd_addr_x, 0);
        chk({pfx, "_rd_y"}, rd_addr_y, 0);
        chk({pfx, "_tw"}, tw_addr, 0);
        chk({pfx, "_wr_x"}, wr_addr_x, 0);
        chk({pfx, "_wr_y"}, wr_addr_y, 0);
    endtask

    // Fixed latency run checked cycle by cycle; optional reset in cycle rst_at.
    task automatic run_fixed(input logic exp_err, input int rst_at);
        int rx, ry, tw, wx, wy;
        bit have_w;
        rx = 0; ry = 0; tw = 0; wx = 0; wy = 0;
        have_w = 1'b0;
        lat_lo = LAT;
        lat_hi = LAT;
        next_cycle();
        start = 1'b1;
        for (int n = 1; n <= DONE_C + 1; n++) begin
            next_cycle();
            start = (n == 5);
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                chk_zero("midrst");
                next_cycle();
                next_cycle();
                reset = 1'b0;
                return;
            end
            if (e_rp[n] >= 0) begin
                rx = exp_rx[e_rp[n]];
                ry = exp_ry[e_rp[n]];
                tw = exp_tw[e_rp[n]];
            end
            if (e_wp[n] >= 0) begin
                wx = exp_wx[e_wp[n]];
                wy = exp_wy[e_wp[n]];
                have_w = 1'b1;
            end
            chk($sformatf("rd_en@%0d", n), rd_en, e_rp[n] >= 0);
            chk($sformatf("bf_en@%0d", n), bf_en, e_bf[n]);
            chk($sformatf("wr_en@%0d", n), wr_en, e_wp[n] >= 0);
            chk($sformatf("busy@%0d", n), busy, n < DONE_C);
            chk($sformatf("done@%0d", n), done, n == DONE_C);
            chk($sformatf("err@%0d", n), err, exp_err);
            chk($sformatf("rd_x@%0d", n), rd_addr_x, rx);
            chk($sformatf("rd_y@%0d", n), rd_addr_y, ry);
            chk($sformatf("tw@%0d", n), tw_addr, tw);
            if (have_w) begin
                chk($sformatf("wr_x@%0d", n), wr_addr_x, wx);
                chk($sformatf("wr_y@%0d", n), wr_addr_y, wy);
            end
        end
        start = 1'b0;
    endtask

    // Random-latency run checked against the ordered read/write lists.
    task automatic run_rand();
        int ri, wi, n;
        bit seen;
        ri = 0; wi = 0; n = 0;
        seen = 1'b0;
        lat_lo = 1;
        lat_hi = 5;
        repeat ($urandom_range(3, 0)) next_cycle();
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        while (!seen && n < 400) begin
            if (rd_en) begin
                if (ri < NP) begin
                    chk($sformatf("rnd_rd_x%0d", ri), rd_addr_x, exp_rx[ri]);
                    chk($sformatf("rnd_rd_y%0d", ri), rd_addr_y, exp_ry[ri]);
                    chk($sformatf("rnd_tw%0d", ri), tw_addr, exp_tw[ri]);
                    chk($sformatf("rnd_order%0d", ri), wi >= (ri / HALF) * HALF, 1);
                end else begin
                    chk("rnd_rd_extra", rd_en, 0);
                end
                ri++;
            end
            if (wr_en) begin
                if (wi < NP) begin
                    chk($sformatf("rnd_wr_x%0d", wi), wr_addr_x, exp_wx[wi]);
                    chk($sformatf("rnd_wr_y%0d", wi), wr_addr_y, exp_wy[wi]);
                end else begin
                    chk("rnd_wr_extra", wr_en, 0);
                end
                wi++;
            end
            if (done) begin
                seen = 1'b1;
                chk("rnd_busy_done", busy, 0);
                chk("rnd_rd_count", ri, NP);
                chk("rnd_wr_count", wi, NP);
            end else begin
                chk("rnd_busy", busy, 1);
                next_cycle();
                n++;
            end
        end
        chk("rnd_done_seen", seen, 1);
        chk("rnd_err", err, 0);
        lat_lo = LAT;
        lat_hi = LAT;
        next_cycle();
    endtask

    initial begin
        build_model();
        next_cycle();
        chk_zero("reset");
        next_cycle();
        reset = 1'b0;
        next_cycle();

        run_fixed(1'b0, 0);
        run_fixed(1'b0, 0);

        inj = 1'b1;
        next_cycle();
        inj = 1'b0;
        chk("idle_valid_wr_en", wr_en, 0);
        chk("idle_valid_err_pre", err, 0);
        next_cycle();
        chk("idle_valid_err", err, 1);

        run_fixed(1'b1, 0);
        run_fixed(1'b1, 12);
        chk_zero("post_rst");
        run_fixed(1'b0, 0);

        for (int r = 0; r < 3; r++) run_rand();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
